// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: function codes,
// FSM state encoding and the iteration-step mode select.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_DIV  = ST_DIV,
    S_FIX  = ST_FIX
  } state_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration step: shift-add for multiply, restoring shift-subtract for
// divide, over the {p_hi, p_lo} accumulator pair and the latched operand b.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] p_hi,
  input  logic [WIDTH-1:0] p_lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nhi,
  output logic [WIDTH-1:0] nlo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Next accumulator value; remainder stays below b so WIDTH+1 bits suffice
  always_comb begin
    sum    = {1'b0, p_hi} + {1'b0, b};
    rem_sh = {p_hi, p_lo[WIDTH-1]};
    diff   = rem_sh - {1'b0, b};
    nhi    = p_hi;
    nlo    = p_lo;
    if (mode == MODE_MUL) begin
      if (p_lo[0]) {nhi, nlo} = {sum, p_lo[WIDTH-1:1]};
      else         {nhi, nlo} = {1'b0, p_hi, p_lo[WIDTH-1:1]};
    end else begin
      if (!diff[WIDTH]) begin
        nhi = diff[WIDTH-1:0];
        nlo = {p_lo[WIDTH-2:0], 1'b1};
      end else begin
        nhi = rem_sh[WIDTH-1:0];
        nlo = {p_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO unit controller: sequences MULT/MULTU/DIV/DIVU one bit per cycle,
// owns HI/LO, services MTHI/MTLO/MFHI/MFLO and stalls EX while busy.
// Optional MULDIV_DIV0_EN: divide by zero short-circuits to FIX, leaves
// HI/LO untouched and pulses div0.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_EN
  ,
  output logic             div0
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   p_hi, p_lo, opb;
  logic [WIDTH-1:0]   nhi, nlo;
  logic               op_div, neg_res, neg_rem;
  logic               is_class, accept, op_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Instruction class decode and handshake
  always_comb begin
    case (funct)
      FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_class = 1'b1;
      default:                            is_class = 1'b0;
    endcase
    stall     = valid & is_class & busy;
    accept    = valid & is_class & ~busy;
    op_signed = (funct == FN_MULT) || (funct == FN_DIV);
    a_abs     = (op_signed && rdata1[WIDTH-1]) ? -rdata1 : rdata1;
    b_abs     = (op_signed && rdata2[WIDTH-1]) ? -rdata2 : rdata2;
  end

  // Move-from read port, same cycle as the request
  always_comb begin
    result = '0;
    if (valid && funct == FN_MFHI)      result = hi;
    else if (valid && funct == FN_MFLO) result = lo;
  end

  // Sign correction applied on the FIX cycle
  always_comb begin
    prod_s = neg_res ? -{p_hi, p_lo} : {p_hi, p_lo};
    if (op_div) begin
      fix_hi = neg_rem ? -p_hi : p_hi;
      fix_lo = neg_res ? -p_lo : p_lo;
    end else begin
      fix_hi = prod_s[2*WIDTH-1:WIDTH];
      fix_lo = prod_s[WIDTH-1:0];
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .mode (op_div ? MODE_DIV : MODE_MUL),
    .p_hi (p_hi),
    .p_lo (p_lo),
    .b    (opb),
    .nhi  (nhi),
    .nlo  (nlo)
  );

  // FSM, iteration counter, accumulator and architectural HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      opb     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
`ifdef MULDIV_DIV0_EN
      div0    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DIV0_EN
      div0 <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (funct)
              FN_MTHI: hi <= rdata1;
              FN_MTLO: lo <= rdata1;
              FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                p_hi    <= '0;
                p_lo    <= a_abs;
                opb     <= b_abs;
                op_div  <= (funct == FN_DIV) || (funct == FN_DIVU);
                neg_res <= op_signed & (rdata1[WIDTH-1] ^ rdata2[WIDTH-1]);
                neg_rem <= op_signed & rdata1[WIDTH-1];
                cnt     <= '0;
                busy    <= 1'b1;
                if (funct == FN_MULT || funct == FN_MULTU) state <= S_MUL;
                else                                       state <= S_DIV;
`ifdef MULDIV_DIV0_EN
                if ((funct == FN_DIV || funct == FN_DIVU) && rdata2 == '0) begin
                  state <= S_FIX;
                  done  <= 1'b1;
                  div0  <= 1'b1;
                end
`endif
              end
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          p_hi <= nhi;
          p_lo <= nlo;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) begin
            state <= S_FIX;
            done  <= 1'b1;
          end
        end
        S_FIX: begin
`ifdef MULDIV_DIV0_EN
          if (!div0) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
`else
          hi <= fix_hi;
          lo <= fix_lo;
`endif
          cnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed operations push expected HI/LO and busy
// length into a scoreboard; a monitor pops and compares when busy falls.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [5:0]   funct;
  logic [W-1:0] rdata1, rdata2;
  logic         stall, busy, done;
  logic [W-1:0] result, hi, lo;
`ifdef MULDIV_DIV0_EN
  logic         div0;
`endif

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .funct  (funct),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hi     (hi),
    .lo     (lo)
`ifdef MULDIV_DIV0_EN
    ,
    .div0   (div0)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles, compare against scoreboard when busy drops
  int   bcnt = 0;
  int   dcnt = 0;
  logic last_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
      dcnt = 0;
    end else if (busy) begin
      bcnt++;
      if (done) dcnt++;
      last_done = done;
    end else if (bcnt != 0) begin
      if (sb.size() == 0) begin
        check("unexpected_op", 64'(bcnt), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_latency"}, 64'(bcnt), 64'(e.lat));
        check({e.name, "_done_cnt"}, 64'(dcnt), 64'd1);
        check({e.name, "_done_last"}, 64'(last_done), 64'd1);
        check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
      end
      bcnt = 0;
      dcnt = 0;
    end
  end

  // All tasks start and end at posedge+1
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    valid  = 1'b1;
    funct  = f;
    rdata1 = a;
    rdata2 = b;
    @(posedge clk); #1;
    valid  = 1'b0;
  endtask

  task automatic op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                    input int lat);
    exp_t e;
    wait_idle();
    e.name = name; e.hi = eh; e.lo = el; e.lat = lat;
    sb.push_back(e);
    issue(f, a, b);
  endtask

  initial begin
    int sc;
    rst = 1'b1; valid = 1'b0; funct = '0; rdata1 = '0; rdata2 = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    op("mult_7_m3", FN_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    op("divu_100_7", FN_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 33);
    op("div_m7_2", FN_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);

    // MTLO then MFLO in back-to-back cycles
    wait_idle();
    issue(FN_MTLO, 32'h1234, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h1234);
    valid = 1'b1; funct = FN_MFLO;
    @(negedge clk);
    check("mflo_result", 64'(result), 64'h1234);
    check("mflo_stall", 64'(stall), 64'd0);
    @(posedge clk); #1 valid = 1'b0;

    // MULTU followed by a held MFHI
    op("multu_3_5", FN_MULTU, 32'd3, 32'd5, 32'h0, 32'hF, 33);
    valid = 1'b1; funct = FN_MFHI;
    sc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      sc++;
    end
    check("mfhi_stall_cycles", 64'(sc), 64'd33);
    check("mfhi_after_result", 64'(result), 64'h0);
    @(posedge clk); #1 valid = 1'b0;

    // Non-class instruction while busy
    op("mult_2_3", FN_MULT, 32'd2, 32'd3, 32'h0, 32'h6, 33);
    valid = 1'b1; funct = 6'h20;
    @(negedge clk);
    check("add_busy_stall", 64'(stall), 64'd0);
    check("add_busy_result", 64'(result), 64'd0);
    @(posedge clk); #1 valid = 1'b0;

    op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    op("div_ovf", FN_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);

`ifdef MULDIV_DIV0_EN
    op("div_by0", FN_DIV, 32'd9, 32'd0, 32'h0, 32'h80000000, 1);
    check("div0_pulse", 64'(div0), 64'd1);
    @(posedge clk); #1;
    check("div0_clear", 64'(div0), 64'd0);
`else
    op("div_by0", FN_DIV, 32'd9, 32'd0, 32'h9, 32'hFFFFFFFF, 33);
`endif

    // Reset in the middle of a divide
    wait_idle();
    issue(FN_MTHI, 32'd5, 32'd0);
    check("mthi_hi", 64'(hi), 64'd5);
    issue(FN_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    op("mult_m4_m5", FN_MULT, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h0, 32'h14, 33);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
